// File: rtl/mem_stage_if.sv
// EX/MEM bus bundle: EX-side inputs plus the registered/decoded MEM-side outputs.
interface mem_stage_if;
  logic [31:0] AO_EX;
  logic [31:0] WD_EX;
  logic [31:0] Instr_EX;
  logic [31:0] Pc_EX;
  logic [31:0] HI_EX;
  logic [31:0] LO_EX;
  logic [2:0]  memop_EX;
  logic        fwd_sel;
  logic [31:0] WB_WD;

  logic [31:0] AO_MEM;
  logic [31:0] Instr_MEM;
  logic [31:0] Pc_MEM;
  logic [31:0] HI_MEM;
  logic [31:0] LO_MEM;
  logic [31:0] RD_MEM;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] BadVAddr;

  modport master (
    output AO_EX, WD_EX, Instr_EX, Pc_EX, HI_EX, LO_EX, memop_EX, fwd_sel, WB_WD,
    input  AO_MEM, Instr_MEM, Pc_MEM, HI_MEM, LO_MEM, RD_MEM, exc_adel, exc_ades, BadVAddr
  );

  modport slave (
    input  AO_EX, WD_EX, Instr_EX, Pc_EX, HI_EX, LO_EX, memop_EX, fwd_sel, WB_WD,
    output AO_MEM, Instr_MEM, Pc_MEM, HI_MEM, LO_MEM, RD_MEM, exc_adel, exc_ades, BadVAddr
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, byte-lane data memory, WB store forwarding
// and load/store address-error detection.
module mem_stage #(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Flush,
  mem_stage_if.slave bus
);

  localparam int unsigned AW       = $clog2(DM_WORDS);
  localparam int unsigned DM_BYTES = 4 * DM_WORDS;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_LW   = 3'b001,
    OP_LH   = 3'b010,
    OP_LB   = 3'b011,
    OP_SW   = 3'b100,
    OP_SH   = 3'b101,
    OP_SB   = 3'b110,
    OP_RSV  = 3'b111
  } memop_e;

  logic [31:0] ao_q, ao_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  memop_e      memop_q, memop_d;

  logic [31:0] mem_q [DM_WORDS];

  logic          is_load_c, is_store_c, misal_c, in_range_c;
  logic          adel_c, ades_c, we_c;
  logic [3:0]    be_c;
  logic [31:0]   sd_c, wdata_c;
  logic [AW-1:0] idx_c;

  // Next EX/MEM contents: a flush inserts an all-zero bubble.
  always_comb begin
    ao_d    = bus.AO_EX;
    wd_d    = bus.WD_EX;
    instr_d = bus.Instr_EX;
    pc_d    = bus.Pc_EX;
    hi_d    = bus.HI_EX;
    lo_d    = bus.LO_EX;
    memop_d = memop_e'(bus.memop_EX);
    if (Flush) begin
      ao_d    = '0;
      wd_d    = '0;
      instr_d = '0;
      pc_d    = '0;
      hi_d    = '0;
      lo_d    = '0;
      memop_d = OP_NONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ao_q    <= '0;
      wd_q    <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      memop_q <= OP_NONE;
    end else begin
      ao_q    <= ao_d;
      wd_q    <= wd_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      memop_q <= memop_d;
    end
  end

  // Decode the instruction in MEM: alignment, range, lane enables and lane data.
  always_comb begin
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    misal_c    = 1'b0;
    be_c       = 4'b0000;
    sd_c       = bus.fwd_sel ? bus.WB_WD : wd_q;
    wdata_c    = sd_c;
    idx_c      = ao_q[AW+1:2];
    in_range_c = (ao_q < 32'(DM_BYTES));
    unique case (memop_q)
      OP_LW: begin
        is_load_c = 1'b1;
        misal_c   = (ao_q[1:0] != 2'b00);
      end
      OP_LH: begin
        is_load_c = 1'b1;
        misal_c   = ao_q[0];
      end
      OP_LB: is_load_c = 1'b1;
      OP_SW: begin
        is_store_c = 1'b1;
        misal_c    = (ao_q[1:0] != 2'b00);
        be_c       = 4'b1111;
      end
      OP_SH: begin
        is_store_c = 1'b1;
        misal_c    = ao_q[0];
        be_c       = ao_q[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{sd_c[15:0]}};
      end
      OP_SB: begin
        is_store_c = 1'b1;
        be_c       = 4'b0001 << ao_q[1:0];
        wdata_c    = {4{sd_c[7:0]}};
      end
      OP_NONE, OP_RSV: ;
    endcase
    adel_c = is_load_c  & (misal_c | ~in_range_c);
    ades_c = is_store_c & (misal_c | ~in_range_c);
    we_c   = is_store_c & ~ades_c;
  end

  // A store already in MEM still commits under Flush; only Reset or a fault blocks it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (we_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  assign bus.AO_MEM    = ao_q;
  assign bus.Instr_MEM = instr_q;
  assign bus.Pc_MEM    = pc_q;
  assign bus.HI_MEM    = hi_q;
  assign bus.LO_MEM    = lo_q;
  assign bus.BadVAddr  = ao_q;
  assign bus.RD_MEM    = mem_q[idx_c];
  assign bus.exc_adel  = adel_c;
  assign bus.exc_ades  = ades_c;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps then random traffic,
// compared against a byte-addressed memory model.
module tb_mem_stage;
  localparam int unsigned DM_WORDS = 1024;
  localparam int unsigned DM_BYTES = 4 * DM_WORDS;

  logic Clk = 1'b0;
  logic Reset;
  logic Flush;

  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(DM_WORDS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Flush (Flush),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm [DM_BYTES];
  logic        pend_valid = 1'b0;
  logic [31:0] pend_addr  = '0;
  logic [31:0] pend_wd    = '0;
  int          pend_size  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a memop, 0 for no memory access.
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 4;
      3'd2, 3'd5: return 2;
      3'd3, 3'd6: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mm[a + 32'(i)];
    return w;
  endfunction

  // One pipeline cycle: fwd/wbwd serve the store currently in MEM, the rest is the new EX instruction.
  task automatic step(input logic rst, input logic fl, input logic [2:0] op,
                      input logic [31:0] ao, input logic [31:0] wd,
                      input logic fwd, input logic [31:0] wbwd);
    logic [31:0] instr, pc, hi, lo, d;
    logic [31:0] e_ao, e_instr, e_pc, e_hi, e_lo, e_wd;
    logic [2:0]  e_op;
    int          sz;
    logic        ld, st, fault;
    instr = $urandom; pc = $urandom; hi = $urandom; lo = $urandom;
    Reset = rst; Flush = fl;
    bus.memop_EX = op; bus.AO_EX = ao; bus.WD_EX = wd;
    bus.Instr_EX = instr; bus.Pc_EX = pc; bus.HI_EX = hi; bus.LO_EX = lo;
    bus.fwd_sel = fwd; bus.WB_WD = wbwd;
    @(posedge Clk);
    #1;
    if (rst) begin
      for (int i = 0; i < int'(DM_BYTES); i++) mm[i] = 8'h00;
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      d = fwd ? wbwd : pend_wd;
      for (int i = 0; i < pend_size; i++) mm[pend_addr + 32'(i)] = d[8*i +: 8];
    end
    if (rst || fl) begin
      e_op = 3'd0; e_ao = '0; e_wd = '0; e_instr = '0; e_pc = '0; e_hi = '0; e_lo = '0;
    end else begin
      e_op = op; e_ao = ao; e_wd = wd; e_instr = instr; e_pc = pc; e_hi = hi; e_lo = lo;
    end
    sz    = op_size(e_op);
    ld    = (e_op >= 3'd1) && (e_op <= 3'd3);
    st    = (e_op >= 3'd4) && (e_op <= 3'd6);
    fault = (sz != 0) && (((e_ao % 32'(sz)) != 0) || (e_ao >= 32'(DM_BYTES)));
    check("AO_MEM",    bus.AO_MEM,    e_ao);
    check("Instr_MEM", bus.Instr_MEM, e_instr);
    check("Pc_MEM",    bus.Pc_MEM,    e_pc);
    check("HI_MEM",    bus.HI_MEM,    e_hi);
    check("LO_MEM",    bus.LO_MEM,    e_lo);
    check("BadVAddr",  bus.BadVAddr,  e_ao);
    check("exc_adel",  32'(bus.exc_adel), 32'(ld && fault));
    check("exc_ades",  32'(bus.exc_ades), 32'(st && fault));
    if (e_ao < 32'(DM_BYTES)) check("RD_MEM", bus.RD_MEM, model_word(e_ao));
    pend_valid = st && !fault;
    pend_addr  = e_ao;
    pend_size  = sz;
    pend_wd    = e_wd;
  endtask

  initial begin
    logic        rst, fl, fwd;
    logic [2:0]  op;
    logic [31:0] ao;
    int          sel;

    // Reset state
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("rst_rd", bus.RD_MEM, 32'h0);

    // sw then lw, same word
    step(1'b0, 1'b0, 3'd4, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'h0);
    check("plan_lw", bus.RD_MEM, 32'hDEADBEEF);

    // Byte and half stores into a prefilled word
    step(1'b0, 1'b0, 3'd4, 32'h20, 32'h11223344, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd6, 32'h22, 32'h000000AA, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h20, 32'h0, 1'b0, 32'h0);
    check("plan_sb", bus.RD_MEM, 32'h11AA3344);
    step(1'b0, 1'b0, 3'd5, 32'h20, 32'h0000BEEF, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h20, 32'h0, 1'b0, 32'h0);
    check("plan_sh", bus.RD_MEM, 32'h11AABEEF);

    // Address errors
    step(1'b0, 1'b0, 3'd4, 32'h12, 32'h55555555, 1'b0, 32'h0);
    check("plan_ades", 32'(bus.exc_ades), 32'd1);
    check("plan_badv", bus.BadVAddr, 32'h12);
    step(1'b0, 1'b0, 3'd2, 32'h21, 32'h0, 1'b0, 32'h0);
    check("plan_adel_h", 32'(bus.exc_adel), 32'd1);
    step(1'b0, 1'b0, 3'd1, 32'h1000, 32'h0, 1'b0, 32'h0);
    check("plan_adel_r", 32'(bus.exc_adel), 32'd1);
    step(1'b0, 1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'h0);
    check("plan_nowr", bus.RD_MEM, 32'hDEADBEEF);

    // Forwarded store data
    step(1'b0, 1'b0, 3'd4, 32'h40, 32'h1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D);
    check("plan_fwd", bus.RD_MEM, 32'hCAFEF00D);

    // Flush: store in MEM commits, store in EX becomes a bubble
    step(1'b0, 1'b0, 3'd4, 32'h60, 32'h00001234, 1'b0, 32'h0);
    step(1'b0, 1'b1, 3'd4, 32'h50, 32'h55, 1'b0, 32'h0);
    check("plan_flush_instr", bus.Instr_MEM, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h50, 32'h0, 1'b0, 32'h0);
    check("plan_flush_nowr", bus.RD_MEM, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h60, 32'h0, 1'b0, 32'h0);
    check("plan_flush_keep", bus.RD_MEM, 32'h00001234);

    // Reset with Flush clears memory too
    step(1'b1, 1'b1, 3'd4, 32'h10, 32'h77, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'h0);
    check("plan_rst_mem", bus.RD_MEM, 32'h0);

    // Random traffic concentrated on a small window to force reuse
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      op  = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      ao = $urandom;
      else if (sel == 1) ao = 32'($urandom_range(4080, 4200));
      else               ao = 32'($urandom_range(0, 255));
      fwd = 1'($urandom_range(0, 1));
      step(rst, fl, op, ao, $urandom, fwd, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
